// File: rtl/npu_loop_seq_pkg.sv
// npu_loop_seq shared package: defaults, bound vector, FSM states.
// Also provides a ceil-division helper for tiled loop bounds.
package npu_loop_seq_pkg;

  localparam int NLVL_DEF   = 4;
  localparam int CNT_W_DEF  = 8;
  localparam int ADDR_W_DEF = 16;

  typedef logic [NLVL_DEF*CNT_W_DEF-1:0] bound_vec_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic int unsigned ceil_div(
    input int unsigned a,
    input int unsigned b
  );
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/npu_loop_seq_if.sv
// npu_loop_seq handshake bundle: config, control and index stream.
// lin_addr exists only when NPU_LOOP_SEQ_LINADDR_EN is defined.
interface npu_loop_seq_if #(
  parameter int NLVL   = 4,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 16
);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [NLVL*CNT_W-1:0] cfg_bound;
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  idx_valid;
  logic                  idx_ready;
  logic [NLVL*CNT_W-1:0] idx;
  logic                  idx_last;
  logic                  done;
`ifdef NPU_LOOP_SEQ_LINADDR_EN
  logic [ADDR_W-1:0]     lin_addr;
`endif

  modport master (
    output cfg_valid, cfg_bound, start,
    output abort, idx_ready,
`ifdef NPU_LOOP_SEQ_LINADDR_EN
    input  lin_addr,
`endif
    input  cfg_ready, busy, idx_valid,
    input  idx, idx_last, done
  );

  modport slave (
    input  cfg_valid, cfg_bound, start,
    input  abort, idx_ready,
`ifdef NPU_LOOP_SEQ_LINADDR_EN
    output lin_addr,
`endif
    output cfg_ready, busy, idx_valid,
    output idx, idx_last, done
  );

endinterface

// File: rtl/npu_loop_stage.sv
// One odometer digit: counter with bound compare, wrap and carry.
// Bound must be >= 1; it only changes while the counter sits at 0.
module npu_loop_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] bound_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o,
  output logic             carry_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max   = cnt_q == bound_i - CNT_W'(1);
  assign at_max_o = at_max;
  assign carry_o  = inc_i && at_max && !clr_i;
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr_i:                     cnt_d = '0;
      !clr_i && inc_i && at_max: cnt_d = '0;
      !clr_i && inc_i && !at_max:
        cnt_d = cnt_q + CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/npu_loop_seq.sv
// Nested-loop index sequencer (odometer over NLVL levels).
// Optional lin_addr output: define NPU_LOOP_SEQ_LINADDR_EN.
module npu_loop_seq
  import npu_loop_seq_pkg::*;
#(
  parameter int NLVL   = NLVL_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  npu_loop_seq_if.slave  bus
);

  state_t state_q, state_d;

  logic [NLVL-1:0][CNT_W-1:0] bnd_q;
  logic [NLVL-1:0][CNT_W-1:0] cnt;
  logic [NLVL-1:0]            at_max;
  logic [NLVL:0]              carry;

  logic cfg_acc, run, xfer, clr;
  logic cfg_rdy, busy_w, ivld, dn;

  assign run     = state_q == S_RUN;
  assign cfg_acc = bus.cfg_valid && state_q == S_IDLE;
  assign xfer    = run && bus.idx_ready && !bus.abort;
  assign clr     = (run && bus.abort) ||
                   (state_q == S_IDLE && bus.start);
  assign carry[0] = xfer;

  // Zero bounds degenerate to a single-trip level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NLVL; l++)
        bnd_q[l] <= CNT_W'(1);
    end else if (cfg_acc) begin
      for (int l = 0; l < NLVL; l++)
        bnd_q[l] <=
          (bus.cfg_bound[l*CNT_W +: CNT_W] == '0) ?
          CNT_W'(1) : bus.cfg_bound[l*CNT_W +: CNT_W];
    end
  end

  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    npu_loop_stage #(.CNT_W(CNT_W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (clr),
      .inc_i    (carry[l]),
      .bound_i  (bnd_q[l]),
      .cnt_o    (cnt[l]),
      .at_max_o (at_max[l]),
      .carry_o  (carry[l+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (bus.abort)       state_d = S_IDLE;
        else if (carry[NLVL]) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_rdy = 1'b0;
    busy_w  = 1'b0;
    ivld    = 1'b0;
    dn      = 1'b0;
    unique case (state_q)
      S_IDLE: cfg_rdy = 1'b1;
      S_RUN: begin
        busy_w = 1'b1;
        ivld   = 1'b1;
      end
      S_DONE:  dn = 1'b1;
      default: ;
    endcase
  end

  assign bus.cfg_ready = cfg_rdy;
  assign bus.busy      = busy_w;
  assign bus.idx_valid = ivld;
  assign bus.done      = dn;
  assign bus.idx       = cnt;
  assign bus.idx_last  = run && (&at_max);

`ifdef NPU_LOOP_SEQ_LINADDR_EN
  logic [ADDR_W-1:0] lin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   lin_q <= '0;
    else if (clr || carry[NLVL])  lin_q <= '0;
    else if (xfer)                lin_q <= lin_q + ADDR_W'(1);
  end

  assign bus.lin_addr = lin_q;
`endif

endmodule

// File: doc/npu_loop_seq.md
NPU_LOOP_SEQ -- requirements
Module: npu_loop_seq

Interface
REQ-001 SHALL have parameter NLVL, default 4, number of nested loop levels (level 0 innermost).
REQ-002 SHALL have parameter CNT_W, default 8, width of each loop bound and index.
REQ-003 SHALL have parameter ADDR_W, default 16, linear-address width (used only with the REQ-030 feature).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_valid  input  1  bound vector offered.
REQ-007 SHALL have port cfg_ready  output  1  bound vector accepted (high only in IDLE).
REQ-008 SHALL have port cfg_bound  input  NLVL*CNT_W  per-level trip counts, level 0 in LSBs.
REQ-009 SHALL have port start  input  1  single-cycle request to run the loaded nest.
REQ-010 SHALL have port abort  input  1  synchronous cancel.
REQ-011 SHALL have port busy  output  1  high in RUN.
REQ-012 SHALL have port idx_valid / idx_ready  output / input  1 / 1  index-tuple handshake.
REQ-013 SHALL have port idx  output  NLVL*CNT_W  current index tuple, level 0 in LSBs.
REQ-014 SHALL have port idx_last  output  1  marks the final tuple of the nest.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last tuple transfers.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; DONE lasts exactly one cycle with done=1.
REQ-017 SHALL capture cfg_bound on cfg_valid&&cfg_ready; a bound of 0 SHALL be treated as 1 (level degenerates).
REQ-018 SHALL leave IDLE for RUN on start; start outside IDLE SHALL be ignored.
REQ-019 SHALL, when cfg_valid and start coincide in IDLE, run with the newly captured bounds.
REQ-020 SHALL assert idx_valid in every RUN cycle; first tuple (all zeros) valid the cycle after start is accepted.
REQ-021 SHALL advance only on idx_valid&&idx_ready; idx SHALL hold stable while idx_valid&&!idx_ready.
REQ-022 SHALL increment level 0 per transfer; on reaching bound-1 a level SHALL wrap to 0 and carry into the next level (odometer order).
REQ-023 SHALL assert idx_last when every level equals bound-1; its transfer SHALL move FSM to DONE with idx_valid=0.
REQ-024 SHALL emit exactly the product of effective bounds tuples per run, no gaps except backpressure.
REQ-025 SHALL on abort in RUN return to IDLE next cycle, clear indices, and not pulse done; abort has priority over a coincident transfer.
REQ-026 SHALL keep outputs registered; no combinational path from idx_ready to idx_valid.

Reset
REQ-027 SHALL on rst_n=0 force IDLE, cfg_ready=1, busy=0, idx_valid=0, idx=0, idx_last=0, done=0, stored bounds=1 per level.
REQ-028 SHALL, on reset asserted mid-RUN, discard the nest; next run needs start (stored bounds are reset).
REQ-029 SHALL release reset without glitching outputs; first active edge sees IDLE.

Configuration
REQ-030 SHALL, with macro NPU_LOOP_SEQ_LINADDR_EN defined, add output lin_addr (ADDR_W), the row-major linear index of the current tuple (transfer count from run start), reset/cleared to 0, stable under backpressure.
REQ-031 SHALL, without NPU_LOOP_SEQ_LINADDR_EN, omit lin_addr port and its counter entirely.

Structure
REQ-032 SHALL take NLVL/CNT_W defaults, a bound-vector typedef and a ceil-division function (for L3/L4-style bounds) from the shared globals package.
REQ-033 SHALL instantiate NLVL copies of sub-module npu_loop_stage (one counter, bound compare, wrap, carry in/out).

Verification
REQ-034 Conv-classifier nest bounds {5,5,16,2}, idx_ready=1 -> 800 tuples, last={4,4,15,1} with idx_last, done 1 cycle later.
REQ-035 FC nest bounds {8,0,15,2} -> level 1 stays 0, 240 tuples, lin_addr ends 239 when macro defined.
REQ-036 Bounds {3,2,1,1}, idx_ready toggled 1/0 -> 6 tuples, idx unchanged on every stalled cycle.
REQ-037 Abort after 10th transfer of {5,5,16,2} -> IDLE next cycle, no done, cfg_ready=1.
REQ-038 All bounds 1 -> single tuple {0,0,0,0} with idx_last=1, then done.
REQ-039 cfg_valid with {2,2,1,1} and start same cycle -> 4 tuples; rst_n low mid-run -> all outputs at reset values immediately.
